// File: rtl/cla_pkg.sv
// cla_pkg: shared FSM state encoding and default sizing for the sequential CLA adder
package cla_pkg;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_NUM_CHUNKS = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/cla_slice.sv
// cla_slice: W-bit carry-lookahead adder slice (a + b + cin -> sum, cout)
module cla_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         pp;

    assign g = a & b;
    assign p = a ^ b;

    // every carry is a flat sum of generate terms gated by propagate chains, no ripple
    always_comb begin
        c    = '0;
        pp   = 1'b1;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
    end

    assign sum  = p ^ c[W-1:0];
    assign cout = c[W];

endmodule

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: operand-wide adder built from one CLA slice reused over NUM_CHUNKS cycles
module cla_seq_ctrl
    import cla_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CHUNKS = DEF_NUM_CHUNKS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*NUM_CHUNKS-1:0] a,
    input  logic [DATA_WIDTH*NUM_CHUNKS-1:0] b,
    input  logic                             cin,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*NUM_CHUNKS-1:0] sum,
    output logic                             cout
);

    localparam int OPW = DATA_WIDTH * NUM_CHUNKS;
    localparam int IW  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_CHUNKS - 1);

    state_t                state;
    logic [IW-1:0]         idx;
    logic                  carry;
    logic [OPW-1:0]        a_reg;
    logic [OPW-1:0]        b_reg;
    logic [DATA_WIDTH-1:0] s_sum;
    logic                  s_cout;

    // slice only sees registered operands and the carry register
    cla_slice #(.W(DATA_WIDTH)) u_slice (
        .a    (a_reg[idx*DATA_WIDTH +: DATA_WIDTH]),
        .b    (b_reg[idx*DATA_WIDTH +: DATA_WIDTH]),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // accept in IDLE, add one chunk per RUN cycle, hold the result in DONE until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= a;
                    b_reg <= b;
                    carry <= cin;
                    idx   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum[idx*DATA_WIDTH +: DATA_WIDTH] <= s_sum;
                    carry <= s_cout;
                    if (idx == LAST) begin
                        cout  <= s_cout;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb_cla_seq_ctrl: directed and random checks of cla_seq_ctrl against a queued a+b+cin model
module tb_cla_seq_ctrl;

    localparam int OPW  = 16;
    localparam int NOPS = 3000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic           cin = 1'b0;
    logic [OPW-1:0] a = '0;
    logic [OPW-1:0] b = '0;
    logic           in_ready;
    logic           out_valid;
    logic [OPW-1:0] sum;
    logic           cout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accepts = 0;
    int pops = 0;
    logic [OPW:0] q[$];

    cla_seq_ctrl #(.DATA_WIDTH(4), .NUM_CHUNKS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // one clock: model the handshakes seen before the edge, then step to #1 after it
    task automatic tick();
        logic [OPW:0] e;
        if (in_valid && in_ready) begin
            q.push_back({1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, cin});
            accepts++;
        end
        if (out_valid && out_ready) begin
            pops++;
            chk("sb_pop_nonempty", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_result", {cout, sum}, e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!out_valid && n < max) begin
            tick();
            n++;
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    initial begin
        int n;
        int c1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst_n = 1'b1;
        tick();

        // 0x1234 + 0x4321: latency exactly 4
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("run_in_ready", in_ready, 0);
        wait_valid(20, n);
        chk("lat_1234", n, 4);
        chk("sum_1234", sum, 16'h5555);
        chk("cout_1234", cout, 0);
        tick();
        chk("idle_after_pop", in_ready, 1);

        // 0xFFFF + 0 + 1: carry through every chunk
        a = 16'hFFFF; b = 16'h0000; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(20, n);
        chk("lat_ffff", n, 4);
        chk("sum_ffff", sum, 16'h0000);
        chk("cout_ffff", cout, 1);
        tick();

        // 0x8000 + 0x8000 with back-pressure in DONE; junk inputs must be ignored
        a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        a = 16'h7777; b = 16'h1111; cin = 1'b1;
        wait_valid(20, n);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_out_valid", out_valid, 1);
            chk("hold_sum", sum, 16'h0000);
            chk("hold_cout", cout, 1);
            chk("hold_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        chk("pop_out_valid", out_valid, 1);
        tick();
        chk("after_pop_in_ready", in_ready, 1);
        chk("after_pop_out_valid", out_valid, 0);

        // in_valid held high, operands changed during RUN: 6-cycle result spacing
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b1; in_valid = 1'b1;
        tick();
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        wait_valid(20, n);
        c1 = cyc;
        chk("first_sum", sum, 16'h1001);
        chk("first_cout", cout, 0);
        tick();
        tick();
        in_valid = 1'b0;
        wait_valid(20, n);
        chk("spacing", cyc - c1, 6);
        chk("second_sum", sum, 16'h0000);
        chk("second_cout", cout, 1);
        tick();

        // reset mid-RUN at idx=2 abandons the operation
        a = 16'h1111; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("partial_sum", sum, 16'h0022);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_sum", sum, 0);
        chk("arst_cout", cout, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        q.delete();
        rst_n = 1'b1;
        a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(20, n);
        chk("lat_after_rst", n, 4);
        chk("sum_after_rst", sum, 16'h0002);
        chk("cout_after_rst", cout, 0);
        tick();

        // random traffic with random valid/ready
        accepts = 0;
        pops = 0;
        while (accepts < NOPS && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = OPW'($urandom);
            b   = OPW'($urandom);
            cin = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("rand_accepts", accepts, NOPS);
        chk("rand_drained", q.size(), 0);
        chk("rand_pops", pops, accepts);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
